temp_pingpong_buf: RTL
======================

// Module: temp_pingpong_buf
// PURPOSE
//  Double-buffered (ping-pong) staging buffer between the parallel MAC array and the next layer.
//  Captures one MAC_CNT-lane accumulator vector per write, quantises each lane to DATA_WIDTH,
//  and streams the lanes out serially with valid/ready handshake, auto-indexed.
//  Two banks: the MAC array can fill one bank while the consumer drains the other.
// PARAMETERS
//  MAC_CNT     128                 lanes per vector (>=2)
//  ACC_WIDTH   20                  signed accumulator width per input lane
//  DATA_WIDTH  8                   signed stored/output width
//  SHIFT       7                   arithmetic right shift applied before saturation (0..ACC_WIDTH-1)
//  RELU_EN     1                   1: negative quantised values forced to 0
//  ADDR_WIDTH  $clog2(MAC_CNT)     lane index width
// PORTS
//  clk_i         in   1                    clock
//  rstn_i        in   1                    asynchronous reset, active-low
//  clear_i       in   1                    synchronous flush of both banks and read stream
//  wr_en_i       in   1                    write request for a full vector
//  wr_ready_o    out  1                    current write bank is empty
//  data_in       in   ACC_WIDTH*MAC_CNT    lane i = data_in[ACC_WIDTH*(MAC_CNT-i)-1 -: ACC_WIDTH] (lane 0 at MSBs)
//  out_valid_o   out  1                    out_data_o holds a valid beat
//  out_ready_i   in   1                    consumer accepts beat
//  out_data_o    out  DATA_WIDTH           quantised lane value
//  out_idx_o     out  ADDR_WIDTH           lane index of current beat
//  out_last_o    out  1                    current beat is lane MAC_CNT-1
//  out_bank_o    out  1                    bank the current beat comes from
// BEHAVIOUR
//  Reset: both banks EMPTY, storage 0, wbank=rbank=0, out_valid_o=0, out_data_o=0, out_idx_o=0,
//   out_last_o=0, out_bank_o=0; wr_ready_o=1 after reset. Reset mid-stream abandons all data.
//  Priority per edge: reset > clear_i > normal operation. clear_i: both banks EMPTY, pointers 0,
//   out_valid_o=0, idx 0; wr_en_i / handshake in the same cycle are ignored. Storage need not be zeroed.
//  Quantise (at write, per lane): q = acc >>> SHIFT; if RELU_EN && q<0 then q=0;
//   saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. No rounding (truncation toward -inf).
//  Write: accepted on an edge when wr_en_i && wr_ready_o; all lanes stored to bank wbank, bank -> FULL,
//   wbank toggles. wr_en_i while !wr_ready_o is dropped (no queuing). wr_ready_o = (bank[wbank]==EMPTY),
//   derived from registered state only.
//  Read FSM: IDLE, STREAM.
//   IDLE: if bank[rbank]==FULL at an edge -> load lane 0 into output regs, out_valid_o=1, -> STREAM.
//    Accept-to-first-valid latency: write accepted at edge k, out_valid_o high after edge k+1.
//   STREAM: out_* hold stable while out_valid_o && !out_ready_i.
//    On transfer of lane i<MAC_CNT-1: load lane i+1 same edge (one beat per cycle sustained).
//    On transfer of lane MAC_CNT-1: bank[rbank] -> EMPTY, rbank toggles; if other bank FULL, load its
//     lane 0 same edge (no bubble between vectors), else out_valid_o=0, -> IDLE.
//  Simultaneous: write into bank X and final beat of bank Y on same edge both take effect. A bank
//   freed on edge e becomes writable from edge e+1 (wr_ready_o rises after e). Both FULL -> wr_ready_o=0.
//  out_last_o = (out_idx_o==MAC_CNT-1) && out_valid_o. Index wraps MAC_CNT-1 -> 0 per vector.
// STRUCTURE
//  Shared package temp_buf_pkg: bank state encoding (EMPTY/FULL), read FSM state encoding (IDLE/STREAM),
//   saturate function signature.
//  Sub-module acc_quantizer (combinational, ACC_WIDTH->DATA_WIDTH, SHIFT, RELU_EN), instantiated
//   MAC_CNT times via generate on the write path. Top holds banks, bank flags, pointers, read FSM.
// TESTING  (bench: MAC_CNT=4, ACC_WIDTH=20, DATA_WIDTH=8, SHIFT=7, RELU_EN=1)
//  1 Write lanes {128,256,-128,32767}, out_ready_i=1 -> valid after edge k+1; beats 1,2,0,127,
//    idx 0..3, out_last_o on beat 4 only, then out_valid_o=0, wr_ready_o=1.
//  2 Two writes back-to-back, out_ready_i=0 -> second accepted, wr_ready_o=0, third write dropped;
//    raise out_ready_i -> 8 contiguous beats, out_bank_o 0 then 1, no bubble at bank switch.
//  3 Backpressure: toggle out_ready_i every cycle -> out_data_o/out_idx_o stable while stalled, no loss/dup.
//  4 Write to freed bank on same edge as its final beat -> wr_en_i dropped (wr_ready_o=0); retry next cycle accepted.
//  5 clear_i asserted mid-stream (at idx 2) together with wr_en_i -> out_valid_o=0 next edge, both banks
//    EMPTY, write ignored; new write then streams from idx 0, bank 0.
//  6 rstn_i pulsed low asynchronously mid-stream -> all outputs 0 immediately, wr_ready_o=1 after release.

Source files
------------

// File: rtl/temp_buf_pkg.sv
// Shared types and helpers for the ping-pong staging buffer between the MAC
// array and the next layer.
package temp_buf_pkg;

  // Occupancy of one storage bank.
  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_e;

  // Read-side stream controller states.
  typedef enum logic {
    RD_IDLE   = 1'b0,
    RD_STREAM = 1'b1
  } rd_state_e;

  // Working width for the saturation helper; wide enough for any realistic
  // accumulator so one function serves every lane configuration.
  localparam int SAT_CALC_WIDTH = 64;

  // Clamp a signed value into the range of a signed 'width'-bit number.
  // The result stays in the wide format; callers keep the low 'width' bits.
  function automatic logic signed [SAT_CALC_WIDTH-1:0] saturate(
    input logic signed [SAT_CALC_WIDTH-1:0] val,
    input int                               width
  );
    logic signed [SAT_CALC_WIDTH-1:0] max_v;
    logic signed [SAT_CALC_WIDTH-1:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (val > max_v) begin
      return max_v;
    end else if (val < min_v) begin
      return min_v;
    end else begin
      return val;
    end
  endfunction

endpackage

// File: rtl/temp_pingpong_buf_acc_quantizer.sv
// Per-lane quantiser: arithmetic right shift (truncation toward -inf),
// optional ReLU, then saturation to the stored data width.
module acc_quantizer
  import temp_buf_pkg::*;
#(
  parameter int ACC_WIDTH  = 20,
  parameter int DATA_WIDTH = 8,
  parameter int SHIFT      = 7,
  parameter bit RELU_EN    = 1'b1
) (
  input  logic [ACC_WIDTH-1:0]  acc,
  output logic [DATA_WIDTH-1:0] q
);

  logic signed [ACC_WIDTH-1:0]      shifted;
  logic signed [SAT_CALC_WIDTH-1:0] widened;
  logic signed [SAT_CALC_WIDTH-1:0] relu_v;

  // Shift in the accumulator's own width; >>> on a signed operand floors.
  assign shifted = $signed(acc) >>> SHIFT;

  // Sign-extend to the saturation helper's working width.
  assign widened = {{(SAT_CALC_WIDTH - ACC_WIDTH){shifted[ACC_WIDTH-1]}}, shifted};

  // ReLU happens before saturation so negatives never reach the lower clamp.
  assign relu_v = (RELU_EN && (widened < 0)) ? '0 : widened;

  assign q = DATA_WIDTH'(saturate(relu_v, DATA_WIDTH));

endmodule

// File: rtl/temp_pingpong_buf.sv
// Two-bank staging buffer: the MAC array writes a whole quantised vector into
// one bank while the consumer drains the other bank one lane per beat.
module temp_pingpong_buf
  import temp_buf_pkg::*;
#(
  parameter int MAC_CNT    = 128,
  parameter int ACC_WIDTH  = 20,
  parameter int DATA_WIDTH = 8,
  parameter int SHIFT      = 7,
  parameter bit RELU_EN    = 1'b1,
  parameter int ADDR_WIDTH = $clog2(MAC_CNT)
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic                         clear_i,
  input  logic                         wr_en_i,
  output logic                         wr_ready_o,
  input  logic [ACC_WIDTH*MAC_CNT-1:0] data_in,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [DATA_WIDTH-1:0]        out_data_o,
  output logic [ADDR_WIDTH-1:0]        out_idx_o,
  output logic                         out_last_o,
  output logic                         out_bank_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(MAC_CNT - 1);

  // Storage and bank bookkeeping.
  logic [DATA_WIDTH-1:0] mem [2][MAC_CNT];
  logic [DATA_WIDTH-1:0] q_lane [MAC_CNT];
  bank_state_e           bank_st [2];
  logic                  wbank;
  logic                  rbank;

  // Read controller state and registered output beat.
  rd_state_e             rd_state;
  rd_state_e             rd_next;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] out_idx;
  logic                  out_bank;

  // Next-beat controls produced by the read controller.
  logic                  load_en;
  logic                  load_bank;
  logic [ADDR_WIDTH-1:0] idx_next;
  logic                  bank_next;
  logic                  valid_next;
  logic                  rbank_next;
  logic                  free_rbank;

  logic                  wr_fire;
  logic                  xfer;

  // One quantiser per lane; lane 0 sits at the MSBs of data_in.
  for (genvar i = 0; i < MAC_CNT; i++) begin : g_lane
    acc_quantizer #(
      .ACC_WIDTH  (ACC_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .SHIFT      (SHIFT),
      .RELU_EN    (RELU_EN)
    ) u_quant (
      .acc (data_in[ACC_WIDTH*(MAC_CNT-i)-1 -: ACC_WIDTH]),
      .q   (q_lane[i])
    );
  end

  // Write side sees only registered occupancy, so a bank freed on this edge
  // becomes writable one cycle later.
  assign wr_ready_o = (bank_st[wbank] == BANK_EMPTY);
  assign wr_fire    = wr_en_i && wr_ready_o;
  assign xfer       = out_valid && out_ready_i;

  // Read controller: decide what the output registers hold after this edge.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_next    = rd_state;
    load_en    = 1'b0;
    load_bank  = rbank;
    idx_next   = out_idx;
    bank_next  = out_bank;
    valid_next = out_valid;
    rbank_next = rbank;
    free_rbank = 1'b0;

    case (rd_state)
      RD_IDLE: begin
        if (bank_st[rbank] == BANK_FULL) begin
          load_en    = 1'b1;
          load_bank  = rbank;
          idx_next   = '0;
          bank_next  = rbank;
          valid_next = 1'b1;
          rd_next    = RD_STREAM;
        end
      end

      RD_STREAM: begin
        if (xfer) begin
          if (out_idx != LAST_IDX) begin
            load_en   = 1'b1;
            load_bank = rbank;
            idx_next  = out_idx + 1'b1;
          end else begin
            // Final lane of this bank: release it and chain straight into
            // the other bank when it is already waiting.
            free_rbank = 1'b1;
            rbank_next = ~rbank;
            if (bank_st[~rbank] == BANK_FULL) begin
              load_en   = 1'b1;
              load_bank = ~rbank;
              idx_next  = '0;
              bank_next = ~rbank;
            end else begin
              idx_next   = '0;
              valid_next = 1'b0;
              rd_next    = RD_IDLE;
            end
          end
        end
      end

      default: rd_next = RD_IDLE;
    endcase
  end

  // Bank occupancy and write/read pointers. A write and a release never hit
  // the same bank on one edge: writes need EMPTY, releases need FULL.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      bank_st[0] <= BANK_EMPTY;
      bank_st[1] <= BANK_EMPTY;
      wbank      <= 1'b0;
      rbank      <= 1'b0;
    end else if (clear_i) begin
      bank_st[0] <= BANK_EMPTY;
      bank_st[1] <= BANK_EMPTY;
      wbank      <= 1'b0;
      rbank      <= 1'b0;
    end else begin
      if (wr_fire) begin
        bank_st[wbank] <= BANK_FULL;
        wbank          <= ~wbank;
      end
      if (free_rbank) begin
        bank_st[rbank] <= BANK_EMPTY;
      end
      rbank <= rbank_next;
    end
  end

  // Vector storage: all lanes of the write bank captured in one edge.
  // NOTE: the arrays are reset because the block must come out of reset with
  // zeroed storage; clear_i leaves contents alone since the EMPTY flags
  // already make stale data unreachable.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < MAC_CNT; i++) begin
          mem[b][i] <= '0;
        end
      end
    end else if (!clear_i && wr_fire) begin
      for (int i = 0; i < MAC_CNT; i++) begin
        mem[wbank][i] <= q_lane[i];
      end
    end
  end

  // Read controller state register and output beat registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rd_state  <= RD_IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_bank  <= 1'b0;
    end else if (clear_i) begin
      rd_state  <= RD_IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_bank  <= 1'b0;
    end else begin
      rd_state  <= rd_next;
      out_valid <= valid_next;
      out_idx   <= idx_next;
      out_bank  <= bank_next;
      if (load_en) begin
        out_data <= mem[load_bank][idx_next];
      end
    end
  end

  assign out_valid_o = out_valid;
  assign out_data_o  = out_data;
  assign out_idx_o   = out_idx;
  assign out_bank_o  = out_bank;
  assign out_last_o  = out_valid && (out_idx == LAST_IDX);

endmodule
